// File: rtl/cra_pkg.sv
// cra_pkg: shared constants and width helpers for the microcode address sequencer
package cra_pkg;
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] force_adr(input int w);
        return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction

    function automatic int sp_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction
endpackage

// File: rtl/cra_seq_if.sv
// cra_seq_if: CRAM field inputs and sequencer status outputs of cra_seq
interface cra_seq_if #(
    parameter int ADR_W  = 11,
    parameter int DEPTH  = 16,
    parameter int DISP_W = 4
);
    import cra_pkg::*;
    localparam int CW = cnt_w(DEPTH);
    logic              advance;
    logic [ADR_W-1:0]  j;
    logic              call;
    logic              ret;
    logic              forceTrap;
    logic              dispEn;
    logic [DISP_W-1:0] dispBits;
    logic              diagLoad;
    logic [ADR_W-1:0]  diagAdr;
    logic              diagClear;
    logic [ADR_W-1:0]  cradr;
    logic [ADR_W-1:0]  sbrRet;
    logic [CW-1:0]     depth;
    logic              overflow;
    logic              underflow;

    modport master (
        output advance, j, call, ret, forceTrap, dispEn, dispBits, diagLoad, diagAdr, diagClear,
        input  cradr, sbrRet, depth, overflow, underflow
    );

    modport slave (
        input  advance, j, call, ret, forceTrap, dispEn, dispBits, diagLoad, diagAdr, diagClear,
        output cradr, sbrRet, depth, overflow, underflow
    );
endinterface

// File: rtl/cra_stack.sv
// cra_stack: circular call/return LIFO that discards the oldest entry when pushed while full
module cra_stack
    import cra_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ADR_W = 11,
    localparam int SPW  = sp_w(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_swap,
    input  logic [ADR_W-1:0] i_din,
    output logic [ADR_W-1:0] o_top,
    output logic [CW-1:0]    o_depth,
    output logic             o_full,
    output logic             o_empty
);
    logic [ADR_W-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic [CW-1:0]    r_cnt;
    logic [SPW-1:0]   w_sp_inc;
    logic [SPW-1:0]   w_sp_dec;
    logic             w_wr_new;

    // r_sp is the next free slot; the top entry sits one slot below it, wrapping at DEPTH
    always_comb begin
        w_sp_inc = (r_sp == SPW'(DEPTH - 1)) ? '0 : r_sp + 1'b1;
        w_sp_dec = (r_sp == '0) ? SPW'(DEPTH - 1) : r_sp - 1'b1;
        o_full   = r_cnt == CW'(DEPTH);
        o_empty  = r_cnt == '0;
        o_top    = o_empty ? '0 : r_mem[w_sp_dec];
        o_depth  = r_cnt;
        w_wr_new = i_push | (i_swap & o_empty);
    end

    // a swap on an empty stack degenerates into a plain push; a pop on empty is a no-op
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_new) begin
            r_mem[r_sp] <= i_din;
            r_sp        <= w_sp_inc;
            r_cnt       <= o_full ? r_cnt : r_cnt + 1'b1;
        end else if (i_swap) begin
            r_mem[w_sp_dec] <= i_din;
        end else if (i_pop && !o_empty) begin
            r_sp  <= w_sp_dec;
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/cra_seq.sv
// cra_seq: registered next-CRAM-address sequencer with call/return stack and sticky status
module cra_seq
    import cra_pkg::*;
#(
    parameter int ADR_W  = 11,
    parameter int DEPTH  = 16,
    parameter int DISP_W = 4,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic      eboxClk,
    input  logic      eboxReset,
    cra_seq_if.slave  bus
);
    localparam logic [ADR_W-1:0] FORCE_ADR = ADR_W'(force_adr(ADR_W));

    logic [ADR_W-1:0] r_cradr;
    logic             r_ov;
    logic             r_uf;
    logic [ADR_W-1:0] w_next;
    logic [ADR_W-1:0] w_disp;
    logic [ADR_W-1:0] w_top;
    logic [CW-1:0]    w_depth;
    logic             w_push;
    logic             w_pop;
    logic             w_swap;
    logic             w_full;
    logic             w_empty;
    logic             w_ov_set;
    logic             w_uf_set;
    logic             w_step;

    cra_stack #(.DEPTH(DEPTH), .ADR_W(ADR_W)) u_stack (
        .clk     (eboxClk),
        .rst     (eboxReset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_swap  (w_swap),
        .i_din   (r_cradr),
        .o_top   (w_top),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // next-address select: force beats diagnostic load beats an advance-qualified step
    always_comb begin
        w_disp   = bus.dispEn ? ADR_W'(bus.dispBits) : '0;
        w_step   = bus.advance & ~bus.forceTrap & ~bus.diagLoad;
        w_push   = bus.forceTrap | (w_step & bus.call & ~bus.ret);
        w_pop    = w_step & bus.ret & ~bus.call;
        w_swap   = w_step & bus.call & bus.ret;
        w_next   = bus.forceTrap ? FORCE_ADR :
                   bus.diagLoad  ? bus.diagAdr :
                   bus.advance   ? ((bus.ret ? w_top : '0) | bus.j | w_disp) : r_cradr;
        w_ov_set = w_push & w_full;
        w_uf_set = (w_pop | w_swap) & w_empty;
    end

    // address register and sticky flags; a new error on the clearing edge keeps its flag set
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            r_cradr <= '0;
            r_ov    <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_cradr <= w_next;
            r_ov    <= w_ov_set | (r_ov & ~bus.diagClear);
            r_uf    <= w_uf_set | (r_uf & ~bus.diagClear);
        end
    end

    assign bus.cradr     = r_cradr;
    assign bus.sbrRet    = w_top;
    assign bus.depth     = w_depth;
    assign bus.overflow  = r_ov;
    assign bus.underflow = r_uf;
endmodule

// File: tb/tb_cra_seq.sv
// tb_cra_seq: directed self-checking bench for cra_seq
module tb_cra_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [28:0] e;

    cra_seq_if #(.ADR_W(11), .DEPTH(16), .DISP_W(4)) bus ();

    cra_seq #(.ADR_W(11), .DEPTH(16), .DISP_W(4)) dut (
        .eboxClk   (clk),
        .eboxReset (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] obs();
        return {bus.cradr, bus.sbrRet, bus.depth, bus.overflow, bus.underflow};
    endfunction

    task automatic cyc(input logic adv, input logic [10:0] jj, input logic c, input logic r,
                       input logic f, input logic de, input logic [3:0] db,
                       input logic dl, input logic [10:0] da, input logic dc);
        bus.advance = adv; bus.j = jj; bus.call = c; bus.ret = r; bus.forceTrap = f;
        bus.dispEn = de; bus.dispBits = db; bus.diagLoad = dl; bus.diagAdr = da; bus.diagClear = dc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1, 11'h3FF, 1, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        e = {11'h000, 11'h000, 5'd0, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL reset got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_dispatch();
        cyc(1, 11'h123, 0, 0, 0, 1, 4'h5, 0, 0, 0);
        e = {11'h127, 11'h000, 5'd0, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL dispatch_en got=%h exp=%h", obs(), e); end
        cyc(1, 11'h120, 0, 0, 0, 0, 4'h5, 0, 0, 0);
        e = {11'h120, 11'h000, 5'd0, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL dispatch_dis got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_call_ret();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 11'h040, 0);
        cyc(1, 11'h200, 1, 0, 0, 0, 0, 0, 0, 0);
        e = {11'h200, 11'h040, 5'd1, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL call got=%h exp=%h", obs(), e); end
        cyc(1, 11'h001, 0, 1, 0, 0, 0, 0, 0, 0);
        e = {11'h041, 11'h000, 5'd0, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL ret got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 17; k++) cyc(1, 11'(k + 1), 1, 0, 0, 0, 0, 0, 0, 0);
        e = {11'h011, 11'h010, 5'd16, 1'b1, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL overflow got=%h exp=%h", obs(), e); end
        for (int k = 16; k >= 1; k--) begin
            cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (bus.cradr !== 11'(k) || bus.depth !== 5'(k - 1)) begin
                n_err++; $display("FAIL unwind%0d got=%h/%0d exp=%h/%0d", k, bus.cradr, bus.depth, k, k - 1);
            end
        end
        cyc(1, 11'h0A8, 0, 1, 0, 1, 4'h3, 0, 0, 0);
        e = {11'h0AB, 11'h000, 5'd0, 1'b1, 1'b1};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL underflow got=%h exp=%h", obs(), e); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e = {11'h0AB, 11'h000, 5'd0, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL diag_clear got=%h exp=%h", obs(), e); end
        cyc(1, 11'h00C, 0, 1, 0, 0, 0, 0, 0, 1);
        e = {11'h00C, 11'h000, 5'd0, 1'b0, 1'b1};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL clear_vs_set got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_force();
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 11'h155, 0);
        cyc(0, 11'h011, 1, 0, 1, 1, 4'hF, 1, 11'h222, 0);
        e = {11'h7FF, 11'h155, 5'd1, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL force got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_swap();
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 11'h010, 0);
        cyc(1, 11'h300, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 11'h000, 1, 1, 0, 0, 0, 0, 0, 0);
        e = {11'h010, 11'h300, 5'd1, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL swap got=%h exp=%h", obs(), e); end
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 11'h222, 0);
        cyc(1, 11'h001, 1, 1, 0, 0, 0, 0, 0, 0);
        e = {11'h001, 11'h222, 5'd1, 1'b0, 1'b1};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL swap_empty got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 11'h050, 0);
        cyc(1, 11'h100, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 11'h000, 0, 1, 0, 0, 0, 0, 0, 0);
        e = {11'h050, 11'h000, 5'd0, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL b2b_pop got=%h exp=%h", obs(), e); end
        cyc(1, 11'h180, 1, 0, 0, 0, 0, 0, 0, 0);
        e = {11'h180, 11'h050, 5'd1, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL b2b_push got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_hold_diag();
        for (int k = 0; k < 3; k++) cyc(0, 11'h007, 1, k[0], 0, 1, 4'h9, 0, 0, 0);
        e = {11'h180, 11'h050, 5'd1, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL hold got=%h exp=%h", obs(), e); end
        cyc(1, 11'h001, 0, 1, 0, 0, 0, 1, 11'h4AA, 0);
        e = {11'h4AA, 11'h050, 5'd1, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL diag_load got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 11'h260, 1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        e = {11'h000, 11'h000, 5'd0, 1'b0, 1'b0};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL reset_mid got=%h exp=%h", obs(), e); end
        cyc(1, 11'h000, 0, 1, 0, 0, 0, 0, 0, 0);
        e = {11'h000, 11'h000, 5'd0, 1'b0, 1'b1};
        n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL post_reset got=%h exp=%h", obs(), e); end
    endtask

    initial begin
        bus.advance = 0; bus.j = 0; bus.call = 0; bus.ret = 0; bus.forceTrap = 0;
        bus.dispEn = 0; bus.dispBits = 0; bus.diagLoad = 0; bus.diagAdr = 0; bus.diagClear = 0;
        test_reset();
        test_dispatch();
        test_call_ret();
        test_overflow();
        test_force();
        test_swap();
        test_back_to_back();
        test_hold_diag();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
